// File: rtl/fetch_unit_if.sv
// Bundle between the fetch stage and its neighbours: the pc block,
// decode and instruction memory. The fetch unit uses the master view
// because it drives the memory request; the slave view is the
// environment (pc block, decode, memory) seen from outside.
interface fetch_unit_if #(
  parameter int DATAWIDTH = 16
);
  // pc block / decode -> fetch
  logic [DATAWIDTH-1:0] pc;
  logic                 redirect;
  logic                 stall;
  // memory -> fetch
  logic [DATAWIDTH-1:0] imem_rdata;
  logic                 imem_ack;
  // fetch -> pc block / memory / decode
  logic                 pcEn;
  logic                 imem_req;
  logic [DATAWIDTH-1:0] imem_addr;
  logic [DATAWIDTH-1:0] ir;
  logic [DATAWIDTH-1:0] ir_pc;
  logic                 ir_valid;
  logic                 fault;

  modport master (
    input  pc, redirect, stall, imem_rdata, imem_ack,
    output pcEn, imem_req, imem_addr, ir, ir_pc, ir_valid, fault
  );

  modport slave (
    output pc, redirect, stall, imem_rdata, imem_ack,
    input  pcEn, imem_req, imem_addr, ir, ir_pc, ir_valid, fault
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Latches the pc into addr_q, runs a req/ack read
// on instruction memory and hands the word to decode through ir/ir_valid.
// A word that arrives while decode is stalled is parked in buf_q (HOLD).
// A redirect seen while a read is outstanding cannot cancel that read, so
// the stage waits for its ack in DRAIN and throws the word away.
// An ack that never comes parks the stage in FAULT until reset.
module fetch_unit #(
  parameter int DATAWIDTH = 16,
  parameter int TIMEOUT   = 16
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam logic [2:0] ST_ISSUE = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_HOLD  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  // Last timer value a request may sit at without ack before faulting.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  logic [2:0]           state_q,    state_d;
  logic [DATAWIDTH-1:0] addr_q,     addr_d;
  logic [DATAWIDTH-1:0] buf_q,      buf_d;
  logic [7:0]           timer_q,    timer_d;
  logic [DATAWIDTH-1:0] ir_q,       ir_d;
  logic [DATAWIDTH-1:0] ir_pc_q,    ir_pc_d;
  logic                 ir_valid_q, ir_valid_d;

  logic                 take;
  logic                 free;
  logic                 pc_en;
  logic                 load;
  logic [DATAWIDTH-1:0] load_word;
  logic                 flush;

  // Decode consumes ir on this edge; ir can accept a new word if empty or consumed.
  assign take = ir_valid_q & ~bus.stall;
  assign free = ~ir_valid_q | take;

  // Fetch sequencing: next state, address latch, buffer, timeout timer, pcEn.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    buf_d     = buf_q;
    timer_d   = timer_q;
    pc_en     = 1'b0;
    load      = 1'b0;
    load_word = buf_q;
    case (state_q)
      ST_ISSUE: begin
        addr_d  = bus.pc;
        timer_d = '0;
        if (bus.redirect) begin
          // pc is being overwritten this edge; pick it up next cycle.
          pc_en = 1'b1;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.redirect && bus.imem_ack) begin
          pc_en   = 1'b1;
          state_d = ST_ISSUE;
        end else if (bus.redirect) begin
          // Read is already in flight; it must still complete at addr_q.
          pc_en   = 1'b1;
          timer_d = timer_q + 8'd1;
          state_d = ST_DRAIN;
        end else if (bus.imem_ack && free) begin
          load      = 1'b1;
          load_word = bus.imem_rdata;
          pc_en     = 1'b1;
          state_d   = ST_ISSUE;
        end else if (bus.imem_ack) begin
          // Decode still holds the previous word; park this one. pc stays put.
          buf_d   = bus.imem_rdata;
          state_d = ST_HOLD;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ST_FAULT;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (bus.redirect) begin
          pc_en   = 1'b1;
          state_d = ST_ISSUE;
        end else if (free) begin
          load      = 1'b1;
          load_word = buf_q;
          pc_en     = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (bus.redirect) begin
          pc_en = 1'b1;
        end
        if (bus.imem_ack) begin
          state_d = ST_ISSUE;
        end else if (timer_q >= TIMER_LAST) begin
          // Timer may already be one past the limit if the redirect hit the last REQ cycle.
          state_d = ST_FAULT;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_ISSUE;
      end
    endcase
  end

  // Instruction register: a flush (redirect or fault entry) beats a load, a load beats a take.
  always_comb begin
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    flush      = (bus.redirect && (state_q != ST_FAULT)) || (state_d == ST_FAULT);
    if (flush) begin
      ir_valid_d = 1'b0;
    end else if (load) begin
      ir_d       = load_word;
      ir_pc_d    = addr_q;
      ir_valid_d = 1'b1;
    end else if (take) begin
      ir_valid_d = 1'b0;
    end
  end

  // State registers; reset drops any outstanding request immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_ISSUE;
      addr_q     <= '0;
      buf_q      <= '0;
      timer_q    <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      buf_q      <= buf_d;
      timer_q    <= timer_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign bus.pcEn      = pc_en;
  assign bus.imem_req  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign bus.imem_addr = addr_q;
  assign bus.ir        = ir_q;
  assign bus.ir_pc     = ir_pc_q;
  assign bus.ir_valid  = ir_valid_q;
  assign bus.fault     = (state_q == ST_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run in which
// the bench plays pc block, decode and memory and checks the delivered
// instruction stream against the expected program order.
module tb_fetch_unit;

  logic clk;
  logic rst;

  fetch_unit_if #(.DATAWIDTH(16)) bus ();

  fetch_unit #(.DATAWIDTH(16), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic        s_req, s_pcen, s_ir_valid, s_fault;
  logic [15:0] s_addr, s_ir, s_ir_pc;
  logic [15:0] target;
  bit          auto_mem;
  int          max_delay;
  int          req_age;
  int          req_delay;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ 16'h1234;
  endfunction

  // One clock: inputs already driven after the previous edge; outputs
  // sampled mid-cycle; the pc-block model updates after the edge.
  task automatic cycle();
    @(negedge clk);
    s_req  = bus.imem_req;
    s_addr = bus.imem_addr;
    if (auto_mem) begin
      if (s_req) begin
        if (req_age == 0) req_delay = int'($urandom_range(0, max_delay));
        bus.imem_ack   = (req_age >= req_delay);
        bus.imem_rdata = bus.imem_ack ? mem_word(s_addr) : 16'($urandom);
        req_age        = bus.imem_ack ? 0 : req_age + 1;
      end else begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'($urandom);
        req_age        = 0;
      end
    end
    #1;
    s_pcen     = bus.pcEn;
    s_ir       = bus.ir;
    s_ir_pc    = bus.ir_pc;
    s_ir_valid = bus.ir_valid;
    s_fault    = bus.fault;
    @(posedge clk);
    #1;
    if (s_pcen) bus.pc = bus.redirect ? target : bus.pc + 16'd1;
  endtask

  task automatic do_reset(input logic [15:0] start_pc);
    rst            = 1'b0;
    auto_mem       = 1'b0;
    bus.pc         = start_pc;
    bus.redirect   = 1'b0;
    bus.stall      = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0;
    target         = 16'h0;
    req_age        = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; auto_mem = 1'b0; bus.pc = 16'h0; bus.redirect = 1'b0; bus.stall = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 16'h0; target = 16'h0;
    @(negedge clk); #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    checks++; if (bus.pcEn !== 1'b0) begin errors++; $display("FAIL reset_pcen: got %b want 0", bus.pcEn); end
    checks++; if (bus.ir_valid !== 1'b0 || bus.fault !== 1'b0) begin errors++; $display("FAIL reset_flags: got valid=%b fault=%b want 0 0", bus.ir_valid, bus.fault); end
    checks++; if (bus.ir !== 16'h0 || bus.ir_pc !== 16'h0 || bus.imem_addr !== 16'h0) begin errors++; $display("FAIL reset_regs: got ir=%h ir_pc=%h addr=%h want 0", bus.ir, bus.ir_pc, bus.imem_addr); end
    // Reset landing in the middle of a request must drop req at once.
    do_reset(16'h0);
    cycle();
    #2;
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL async_pre_req: got %b want 1", bus.imem_req); end
    rst = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL async_drop_req: got %b want 0", bus.imem_req); end
    $display("test_reset done: errors=%0d", errors);
  endtask

  task automatic test_basic_fetch();
    int pcen_cnt;
    pcen_cnt = 0;
    do_reset(16'h0);
    cycle(); pcen_cnt += int'(s_pcen);
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL basic_issue_req: got %b want 0", s_req); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hA001;
    cycle(); pcen_cnt += int'(s_pcen);
    checks++; if (s_req !== 1'b1 || s_addr !== 16'h0 || s_pcen !== 1'b1) begin errors++; $display("FAIL basic_req: got req=%b addr=%h pcEn=%b want 1 0000 1", s_req, s_addr, s_pcen); end
    bus.imem_ack = 1'b0;
    cycle(); pcen_cnt += int'(s_pcen);
    checks++; if (s_ir !== 16'hA001 || s_ir_pc !== 16'h0 || s_ir_valid !== 1'b1) begin errors++; $display("FAIL basic_ir: got ir=%h ir_pc=%h valid=%b want a001 0000 1", s_ir, s_ir_pc, s_ir_valid); end
    checks++; if (pcen_cnt != 1) begin errors++; $display("FAIL basic_pcen_count: got %0d want 1", pcen_cnt); end
    $display("test_basic_fetch done: errors=%0d", errors);
  endtask

  task automatic test_delayed_ack();
    int pcen_cnt;
    pcen_cnt = 0;
    do_reset(16'h0100);
    cycle(); pcen_cnt += int'(s_pcen);
    for (int i = 0; i < 5; i++) begin
      cycle(); pcen_cnt += int'(s_pcen);
      checks++; if (s_req !== 1'b1 || s_addr !== 16'h0100 || s_pcen !== 1'b0) begin errors++; $display("FAIL delay_wait%0d: got req=%b addr=%h pcEn=%b want 1 0100 0", i, s_req, s_addr, s_pcen); end
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hB0B0;
    cycle(); pcen_cnt += int'(s_pcen);
    checks++; if (s_req !== 1'b1 || s_addr !== 16'h0100 || s_pcen !== 1'b1) begin errors++; $display("FAIL delay_ack: got req=%b addr=%h pcEn=%b want 1 0100 1", s_req, s_addr, s_pcen); end
    bus.imem_ack = 1'b0;
    cycle(); pcen_cnt += int'(s_pcen);
    checks++; if (s_ir !== 16'hB0B0 || s_ir_pc !== 16'h0100 || s_ir_valid !== 1'b1 || s_fault !== 1'b0) begin errors++; $display("FAIL delay_ir: got ir=%h ir_pc=%h valid=%b fault=%b want b0b0 0100 1 0", s_ir, s_ir_pc, s_ir_valid, s_fault); end
    checks++; if (pcen_cnt != 1 || bus.pc !== 16'h0101) begin errors++; $display("FAIL delay_pcen: got count=%0d pc=%h want 1 0101", pcen_cnt, bus.pc); end
    $display("test_delayed_ack done: errors=%0d", errors);
  endtask

  task automatic test_stall_hold();
    do_reset(16'h0200);
    bus.stall = 1'b1;
    cycle();
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h1111;
    cycle();
    checks++; if (s_pcen !== 1'b1) begin errors++; $display("FAIL hold_first_load: got pcEn=%b want 1", s_pcen); end
    bus.imem_ack = 1'b0;
    cycle();
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h2222;
    cycle();
    checks++; if (s_req !== 1'b1 || s_addr !== 16'h0201 || s_pcen !== 1'b0) begin errors++; $display("FAIL hold_enter: got req=%b addr=%h pcEn=%b want 1 0201 0", s_req, s_addr, s_pcen); end
    bus.imem_ack = 1'b0;
    cycle();
    checks++; if (s_req !== 1'b0 || s_pcen !== 1'b0 || s_ir !== 16'h1111 || s_ir_valid !== 1'b1) begin errors++; $display("FAIL hold_wait: got req=%b pcEn=%b ir=%h valid=%b want 0 0 1111 1", s_req, s_pcen, s_ir, s_ir_valid); end
    bus.stall = 1'b0;
    cycle();
    checks++; if (s_pcen !== 1'b1 || s_ir !== 16'h1111) begin errors++; $display("FAIL hold_release: got pcEn=%b ir=%h want 1 1111", s_pcen, s_ir); end
    cycle();
    checks++; if (s_ir !== 16'h2222 || s_ir_pc !== 16'h0201 || s_ir_valid !== 1'b1 || bus.pc !== 16'h0202) begin errors++; $display("FAIL hold_next: got ir=%h ir_pc=%h valid=%b pc=%h want 2222 0201 1 0202", s_ir, s_ir_pc, s_ir_valid, bus.pc); end
    cycle();
    checks++; if (s_ir_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 16'h0202) begin errors++; $display("FAIL hold_nodup: got valid=%b req=%b addr=%h want 0 1 0202", s_ir_valid, s_req, s_addr); end
    $display("test_stall_hold done: errors=%0d", errors);
  endtask

  task automatic test_redirect_drain();
    do_reset(16'h0010);
    bus.stall = 1'b1;
    cycle();
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h3333;
    cycle();
    bus.imem_ack = 1'b0;
    cycle();
    cycle();
    checks++; if (s_req !== 1'b1 || s_addr !== 16'h0011 || s_pcen !== 1'b0) begin errors++; $display("FAIL drain_req: got req=%b addr=%h pcEn=%b want 1 0011 0", s_req, s_addr, s_pcen); end
    bus.redirect = 1'b1; target = 16'h0040;
    cycle();
    checks++; if (s_pcen !== 1'b1) begin errors++; $display("FAIL drain_redirect_pcen: got %b want 1", s_pcen); end
    bus.redirect = 1'b0;
    cycle();
    checks++; if (s_req !== 1'b1 || s_addr !== 16'h0011 || s_ir_valid !== 1'b0 || s_pcen !== 1'b0) begin errors++; $display("FAIL drain_state: got req=%b addr=%h valid=%b pcEn=%b want 1 0011 0 0", s_req, s_addr, s_ir_valid, s_pcen); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hDEAD;
    cycle();
    checks++; if (s_pcen !== 1'b0) begin errors++; $display("FAIL drain_ack_pcen: got %b want 0", s_pcen); end
    bus.imem_ack = 1'b0;
    cycle();
    checks++; if (s_req !== 1'b0 || s_ir_valid !== 1'b0) begin errors++; $display("FAIL drain_discard: got req=%b valid=%b want 0 0", s_req, s_ir_valid); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h4444;
    cycle();
    checks++; if (s_req !== 1'b1 || s_addr !== 16'h0040) begin errors++; $display("FAIL drain_new_addr: got req=%b addr=%h want 1 0040", s_req, s_addr); end
    bus.imem_ack = 1'b0;
    cycle();
    checks++; if (s_ir !== 16'h4444 || s_ir_pc !== 16'h0040 || s_ir_valid !== 1'b1) begin errors++; $display("FAIL drain_new_ir: got ir=%h ir_pc=%h valid=%b want 4444 0040 1", s_ir, s_ir_pc, s_ir_valid); end
    $display("test_redirect_drain done: errors=%0d", errors);
  endtask

  task automatic test_redirect_ack();
    int pcen_cnt;
    pcen_cnt = 0;
    do_reset(16'h0080);
    cycle();
    bus.redirect = 1'b1; target = 16'h0090; bus.imem_ack = 1'b1; bus.imem_rdata = 16'hBAD0;
    cycle(); pcen_cnt += int'(s_pcen);
    checks++; if (s_pcen !== 1'b1) begin errors++; $display("FAIL rack_pcen: got %b want 1", s_pcen); end
    bus.redirect = 1'b0; bus.imem_ack = 1'b0;
    cycle(); pcen_cnt += int'(s_pcen);
    checks++; if (s_ir_valid !== 1'b0 || s_req !== 1'b0) begin errors++; $display("FAIL rack_dropped: got valid=%b req=%b want 0 0", s_ir_valid, s_req); end
    cycle(); pcen_cnt += int'(s_pcen);
    checks++; if (s_req !== 1'b1 || s_addr !== 16'h0090) begin errors++; $display("FAIL rack_new_addr: got req=%b addr=%h want 1 0090", s_req, s_addr); end
    checks++; if (pcen_cnt != 1 || bus.pc !== 16'h0090) begin errors++; $display("FAIL rack_count: got count=%0d pc=%h want 1 0090", pcen_cnt, bus.pc); end
    $display("test_redirect_ack done: errors=%0d", errors);
  endtask

  task automatic test_timeout();
    do_reset(16'h0300);
    bus.stall = 1'b1;
    cycle();
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h7777;
    cycle();
    bus.imem_ack = 1'b0;
    cycle();
    for (int i = 0; i < 16; i++) begin
      cycle();
      checks++; if (s_req !== 1'b1 || s_fault !== 1'b0 || s_addr !== 16'h0301) begin errors++; $display("FAIL tmo_wait%0d: got req=%b fault=%b addr=%h want 1 0 0301", i, s_req, s_fault, s_addr); end
    end
    cycle();
    checks++; if (s_fault !== 1'b1 || s_req !== 1'b0 || s_ir_valid !== 1'b0) begin errors++; $display("FAIL tmo_fault: got fault=%b req=%b valid=%b want 1 0 0", s_fault, s_req, s_ir_valid); end
    bus.redirect = 1'b1; target = 16'h0500; bus.imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (s_fault !== 1'b1 || s_req !== 1'b0 || s_pcen !== 1'b0) begin errors++; $display("FAIL tmo_sticky%0d: got fault=%b req=%b pcEn=%b want 1 0 0", i, s_fault, s_req, s_pcen); end
    end
    do_reset(16'h0300);
    cycle();
    checks++; if (s_fault !== 1'b0) begin errors++; $display("FAIL tmo_cleared: got %b want 0", s_fault); end
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h5555;
    cycle();
    bus.imem_ack = 1'b0;
    cycle();
    checks++; if (s_ir !== 16'h5555 || s_ir_pc !== 16'h0300 || s_ir_valid !== 1'b1) begin errors++; $display("FAIL tmo_resume: got ir=%h ir_pc=%h valid=%b want 5555 0300 1", s_ir, s_ir_pc, s_ir_valid); end
    $display("test_timeout done: errors=%0d", errors);
  endtask

  // Program-order model: each instruction decode accepts must come from the
  // address after the previous one, or from the latest redirect target.
  task automatic test_random();
    logic [15:0] exp_next;
    logic        prev_req, prev_ack, prev_redirect;
    logic [15:0] prev_addr;
    int          taken;
    do_reset(16'($urandom));
    exp_next = bus.pc;
    auto_mem = 1'b1;
    max_delay = 4;
    prev_req = 1'b0; prev_ack = 1'b0; prev_redirect = 1'b0; prev_addr = 16'h0;
    taken = 0;
    for (int n = 0; n < 600; n++) begin
      bus.stall    = ($urandom_range(0, 9) < 3);
      bus.redirect = ($urandom_range(0, 11) == 0);
      target       = 16'($urandom);
      cycle();
      if (s_req && prev_req && !prev_ack) begin
        checks++; if (s_addr !== prev_addr) begin errors++; $display("FAIL rnd_addr_stable@%0d: got %h want %h", n, s_addr, prev_addr); end
      end
      if (bus.redirect) begin
        checks++; if (s_pcen !== 1'b1) begin errors++; $display("FAIL rnd_redirect_pcen@%0d: got %b want 1", n, s_pcen); end
      end
      if (prev_redirect) begin
        checks++; if (s_ir_valid !== 1'b0) begin errors++; $display("FAIL rnd_flush@%0d: got valid=%b want 0", n, s_ir_valid); end
      end
      if (s_ir_valid === 1'b1 && !bus.stall) begin
        taken++;
        checks++; if (s_ir_pc !== exp_next || s_ir !== mem_word(exp_next)) begin errors++; $display("FAIL rnd_stream@%0d: got ir_pc=%h ir=%h want %h %h", n, s_ir_pc, s_ir, exp_next, mem_word(exp_next)); end
        exp_next = exp_next + 16'd1;
      end
      if (bus.redirect) exp_next = target;
      checks++; if (s_fault !== 1'b0) begin errors++; $display("FAIL rnd_fault@%0d: got %b want 0", n, s_fault); end
      prev_req = s_req; prev_ack = bus.imem_ack; prev_addr = s_addr; prev_redirect = bus.redirect;
    end
    checks++; if (taken < 50) begin errors++; $display("FAIL rnd_progress: got %0d instructions want at least 50", taken); end
    auto_mem = 1'b0;
    bus.redirect = 1'b0;
    bus.stall = 1'b0;
    $display("test_random done: %0d instructions taken, errors=%0d", taken, errors);
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_delayed_ack();
    test_stall_hold();
    test_redirect_drain();
    test_redirect_ack();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
